// File: rtl/uart_pkg.sv
// Shared UART register map, AXI response codes and FSM state types for the
// UART write-side buffer.
package uart_pkg;

    localparam logic [3:0] UART_RX_ADDR   = 4'h0;
    localparam logic [3:0] UART_TX_ADDR   = 4'h4;
    localparam logic [3:0] UART_STAT_ADDR = 4'h8;
    localparam logic [3:0] UART_CTRL_ADDR = 4'hC;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        A_IDLE,
        A_RESP,
        A_PASS
    } accept_state_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_SEND,
        D_RESP,
        D_GAP
    } drain_state_t;

endpackage

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Byte FIFO for queued TX writes: show-ahead read, simultaneous push/pop
// permitted even when full.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 11
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic                  do_push;
    logic                  do_pop;

    // Count can only reach DEPTH, so its top bit alone marks full.
    assign full     = count_reg[DEPTH_LOG2];
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Queues MMU byte writes to the UART TX register and replays them at line rate;
// other writes pass through in order. UART_TX_BUFFER_OVERFLOW_DROP_EN drops bytes on full.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2  = 11,
    parameter int BYTE_CYCLES = 8680
) (
`ifdef UART_TX_BUFFER_OVERFLOW_DROP_EN
    output logic [15:0] tx_drop_count,
`endif
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  mmu_axi_awaddr,
    input  logic        mmu_axi_awvalid,
    output logic        mmu_axi_awready,
    input  logic [2:0]  mmu_axi_awprot,
    input  logic [31:0] mmu_axi_wdata,
    input  logic [3:0]  mmu_axi_wstrb,
    input  logic        mmu_axi_wvalid,
    output logic        mmu_axi_wready,
    output logic [1:0]  mmu_axi_bresp,
    output logic        mmu_axi_bvalid,
    input  logic        mmu_axi_bready,
    output logic [3:0]  uart_axi_awaddr,
    output logic        uart_axi_awvalid,
    input  logic        uart_axi_awready,
    output logic [2:0]  uart_axi_awprot,
    output logic [31:0] uart_axi_wdata,
    output logic [3:0]  uart_axi_wstrb,
    output logic        uart_axi_wvalid,
    input  logic        uart_axi_wready,
    input  logic [1:0]  uart_axi_bresp,
    input  logic        uart_axi_bvalid,
    output logic        uart_axi_bready
);

    localparam int                GAP_W    = $clog2(BYTE_CYCLES + 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(BYTE_CYCLES - 1);

    accept_state_t a_state_reg, a_state_next;
    drain_state_t  d_state_reg, d_state_next;

    logic        aw_lat_reg, w_lat_reg, lat_clear;
    logic [3:0]  addr_reg;
    logic [2:0]  prot_reg;
    logic [31:0] data_reg;
    logic [3:0]  strb_reg;
    logic        bvalid_reg, bvalid_next;
    logic [1:0]  bresp_reg, bresp_next;
    logic        pass_req_reg, pass_post, pass_take, pass_done;
    logic        is_pass_reg, is_pass_next;
    logic        u_awvalid_reg, u_awvalid_next, u_wvalid_reg, u_wvalid_next;
    logic        u_bready_reg, u_bready_next;
    logic [3:0]  u_awaddr_reg, u_awaddr_next, u_wstrb_reg, u_wstrb_next;
    logic [2:0]  u_awprot_reg, u_awprot_next;
    logic [31:0] u_wdata_reg, u_wdata_next;
    logic [GAP_W-1:0] gap_reg, gap_next;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]        fifo_dout;
    logic [DEPTH_LOG2:0] fifo_count;

`ifdef UART_TX_BUFFER_OVERFLOW_DROP_EN
    logic        drop_inc;
    logic [15:0] drop_count_reg;
    assign tx_drop_count = drop_count_reg;
`endif

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (fifo_push),
        .push_data (data_reg[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign mmu_axi_awready  = !aw_lat_reg;
    assign mmu_axi_wready   = !w_lat_reg;
    assign mmu_axi_bvalid   = bvalid_reg;
    assign mmu_axi_bresp    = bresp_reg;
    assign uart_axi_awaddr  = u_awaddr_reg;
    assign uart_axi_awvalid = u_awvalid_reg;
    assign uart_axi_awprot  = u_awprot_reg;
    assign uart_axi_wdata   = u_wdata_reg;
    assign uart_axi_wstrb   = u_wstrb_reg;
    assign uart_axi_wvalid  = u_wvalid_reg;
    assign uart_axi_bready  = u_bready_reg;

    always_comb begin
        a_state_next = a_state_reg;
        bvalid_next  = bvalid_reg;
        bresp_next   = bresp_reg;
        fifo_push    = 1'b0;
        pass_post    = 1'b0;
        lat_clear    = 1'b0;
`ifdef UART_TX_BUFFER_OVERFLOW_DROP_EN
        drop_inc     = 1'b0;
`endif
        case (a_state_reg)
            A_IDLE: begin
                if (aw_lat_reg && w_lat_reg) begin
                    if (addr_reg == UART_TX_ADDR) begin
                        if (!fifo_full || fifo_pop) begin
                            fifo_push    = 1'b1;
                            bvalid_next  = 1'b1;
                            bresp_next   = RESP_OKAY;
                            a_state_next = A_RESP;
                        end
`ifdef UART_TX_BUFFER_OVERFLOW_DROP_EN
                        else begin
                            drop_inc     = 1'b1;
                            bvalid_next  = 1'b1;
                            bresp_next   = RESP_SLVERR;
                            a_state_next = A_RESP;
                        end
`endif
                    // Passthrough waits for every earlier TX byte to finish.
                    end else if (fifo_count == '0 && d_state_reg == D_IDLE) begin
                        pass_post    = 1'b1;
                        a_state_next = A_PASS;
                    end
                end
            end
            A_PASS: begin
                if (pass_done) begin
                    bvalid_next  = 1'b1;
                    bresp_next   = uart_axi_bresp;
                    a_state_next = A_RESP;
                end
            end
            A_RESP: begin
                if (mmu_axi_bready) begin
                    bvalid_next  = 1'b0;
                    lat_clear    = 1'b1;
                    a_state_next = A_IDLE;
                end
            end
            default: a_state_next = A_IDLE;
        endcase
    end

    always_comb begin
        d_state_next   = d_state_reg;
        u_awvalid_next = u_awvalid_reg;
        u_wvalid_next  = u_wvalid_reg;
        u_bready_next  = u_bready_reg;
        u_awaddr_next  = u_awaddr_reg;
        u_awprot_next  = u_awprot_reg;
        u_wdata_next   = u_wdata_reg;
        u_wstrb_next   = u_wstrb_reg;
        is_pass_next   = is_pass_reg;
        gap_next       = gap_reg;
        fifo_pop       = 1'b0;
        pass_take      = 1'b0;
        pass_done      = 1'b0;
        case (d_state_reg)
            D_IDLE: begin
                if (pass_req_reg) begin
                    pass_take      = 1'b1;
                    is_pass_next   = 1'b1;
                    u_awaddr_next  = addr_reg;
                    u_awprot_next  = prot_reg;
                    u_wdata_next   = data_reg;
                    u_wstrb_next   = strb_reg;
                    u_awvalid_next = 1'b1;
                    u_wvalid_next  = 1'b1;
                    d_state_next   = D_SEND;
                end else if (!fifo_empty) begin
                    fifo_pop       = 1'b1;
                    is_pass_next   = 1'b0;
                    u_awaddr_next  = UART_TX_ADDR;
                    u_awprot_next  = 3'b000;
                    u_wdata_next   = {24'b0, fifo_dout};
                    u_wstrb_next   = 4'b0001;
                    u_awvalid_next = 1'b1;
                    u_wvalid_next  = 1'b1;
                    d_state_next   = D_SEND;
                end
            end
            D_SEND: begin
                u_awvalid_next = u_awvalid_reg && !uart_axi_awready;
                u_wvalid_next  = u_wvalid_reg && !uart_axi_wready;
                if (!u_awvalid_next && !u_wvalid_next) begin
                    u_bready_next = 1'b1;
                    d_state_next  = D_RESP;
                end
            end
            D_RESP: begin
                if (uart_axi_bvalid) begin
                    u_bready_next = 1'b0;
                    if (is_pass_reg) begin
                        pass_done    = 1'b1;
                        d_state_next = D_IDLE;
                    end else begin
                        gap_next     = GAP_LOAD;
                        d_state_next = D_GAP;
                    end
                end
            end
            D_GAP: begin
                if (gap_reg == '0) begin
                    d_state_next = D_IDLE;
                end else begin
                    gap_next = gap_reg - GAP_W'(1);
                end
            end
            default: d_state_next = D_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_state_reg   <= A_IDLE;
            d_state_reg   <= D_IDLE;
            aw_lat_reg    <= 1'b0;
            w_lat_reg     <= 1'b0;
            addr_reg      <= '0;
            prot_reg      <= '0;
            data_reg      <= '0;
            strb_reg      <= '0;
            bvalid_reg    <= 1'b0;
            bresp_reg     <= RESP_OKAY;
            pass_req_reg  <= 1'b0;
            is_pass_reg   <= 1'b0;
            u_awvalid_reg <= 1'b0;
            u_wvalid_reg  <= 1'b0;
            u_bready_reg  <= 1'b0;
            u_awaddr_reg  <= '0;
            u_awprot_reg  <= '0;
            u_wdata_reg   <= '0;
            u_wstrb_reg   <= '0;
            gap_reg       <= '0;
        end else begin
            a_state_reg   <= a_state_next;
            d_state_reg   <= d_state_next;
            bvalid_reg    <= bvalid_next;
            bresp_reg     <= bresp_next;
            pass_req_reg  <= (pass_req_reg || pass_post) && !pass_take;
            is_pass_reg   <= is_pass_next;
            u_awvalid_reg <= u_awvalid_next;
            u_wvalid_reg  <= u_wvalid_next;
            u_bready_reg  <= u_bready_next;
            u_awaddr_reg  <= u_awaddr_next;
            u_awprot_reg  <= u_awprot_next;
            u_wdata_reg   <= u_wdata_next;
            u_wstrb_reg   <= u_wstrb_next;
            gap_reg       <= gap_next;
            if (lat_clear) begin
                aw_lat_reg <= 1'b0;
                w_lat_reg  <= 1'b0;
            end else begin
                if (mmu_axi_awvalid && !aw_lat_reg) begin
                    aw_lat_reg <= 1'b1;
                    addr_reg   <= mmu_axi_awaddr;
                    prot_reg   <= mmu_axi_awprot;
                end
                if (mmu_axi_wvalid && !w_lat_reg) begin
                    w_lat_reg <= 1'b1;
                    data_reg  <= mmu_axi_wdata;
                    strb_reg  <= mmu_axi_wstrb;
                end
            end
        end
    end

`ifdef UART_TX_BUFFER_OVERFLOW_DROP_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_count_reg <= '0;
        end else if (drop_inc && drop_count_reg != 16'hFFFF) begin
            drop_count_reg <= drop_count_reg + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: MMU-side write driver, a UART-lite slave
// responder that logs every launch, and hand-computed expectations.
module tb_uart_tx_buffer;

    localparam int DEPTH_LOG2  = 2;
    localparam int BYTE_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  mmu_axi_awaddr;
    logic        mmu_axi_awvalid;
    logic        mmu_axi_awready;
    logic [2:0]  mmu_axi_awprot;
    logic [31:0] mmu_axi_wdata;
    logic [3:0]  mmu_axi_wstrb;
    logic        mmu_axi_wvalid;
    logic        mmu_axi_wready;
    logic [1:0]  mmu_axi_bresp;
    logic        mmu_axi_bvalid;
    logic        mmu_axi_bready;
    logic [3:0]  uart_axi_awaddr;
    logic        uart_axi_awvalid;
    logic        uart_axi_awready;
    logic [2:0]  uart_axi_awprot;
    logic [31:0] uart_axi_wdata;
    logic [3:0]  uart_axi_wstrb;
    logic        uart_axi_wvalid;
    logic        uart_axi_wready;
    logic [1:0]  uart_axi_bresp;
    logic        uart_axi_bvalid;
    logic        uart_axi_bready;
`ifdef UART_TX_BUFFER_OVERFLOW_DROP_EN
    logic [15:0] tx_drop_count;
`endif

    uart_tx_buffer #(.DEPTH_LOG2(DEPTH_LOG2), .BYTE_CYCLES(BYTE_CYCLES)) dut (
`ifdef UART_TX_BUFFER_OVERFLOW_DROP_EN
        .tx_drop_count   (tx_drop_count),
`endif
        .clk             (clk),
        .rstn            (rstn),
        .mmu_axi_awaddr  (mmu_axi_awaddr),
        .mmu_axi_awvalid (mmu_axi_awvalid),
        .mmu_axi_awready (mmu_axi_awready),
        .mmu_axi_awprot  (mmu_axi_awprot),
        .mmu_axi_wdata   (mmu_axi_wdata),
        .mmu_axi_wstrb   (mmu_axi_wstrb),
        .mmu_axi_wvalid  (mmu_axi_wvalid),
        .mmu_axi_wready  (mmu_axi_wready),
        .mmu_axi_bresp   (mmu_axi_bresp),
        .mmu_axi_bvalid  (mmu_axi_bvalid),
        .mmu_axi_bready  (mmu_axi_bready),
        .uart_axi_awaddr (uart_axi_awaddr),
        .uart_axi_awvalid(uart_axi_awvalid),
        .uart_axi_awready(uart_axi_awready),
        .uart_axi_awprot (uart_axi_awprot),
        .uart_axi_wdata  (uart_axi_wdata),
        .uart_axi_wstrb  (uart_axi_wstrb),
        .uart_axi_wvalid (uart_axi_wvalid),
        .uart_axi_wready (uart_axi_wready),
        .uart_axi_bresp  (uart_axi_bresp),
        .uart_axi_bvalid (uart_axi_bvalid),
        .uart_axi_bready (uart_axi_bready)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_vec = 0;
    int n_err = 0;

    // UART slave controls and launch log
    logic        hold_aw   = 1'b0;
    logic [1:0]  pass_resp = 2'b00;
    int          mon_n = 0;
    int          mb_n  = 0;
    logic [3:0]  mon_addr [64];
    logic [31:0] mon_data [64];
    logic [3:0]  mon_strb [64];
    int          mon_cyc  [64];
    int          mb_cyc   [64];
    bit          s_aw_seen = 0, s_w_seen = 0, s_b_fire = 0;
    logic [3:0]  s_addr    = 4'h0;
    logic        s_prev_av = 1'b0;

    initial begin : uart_slave
        uart_axi_awready = 1'b0;
        uart_axi_wready  = 1'b0;
        uart_axi_bvalid  = 1'b0;
        uart_axi_bresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                s_aw_seen = 0; s_w_seen = 0; s_b_fire = 0;
                uart_axi_bvalid = 1'b0;
            end
            if (s_b_fire) begin
                uart_axi_bvalid = 1'b0;
                s_b_fire = 0;
            end
            if (s_aw_seen && s_w_seen && !uart_axi_bvalid) begin
                uart_axi_bvalid = 1'b1;
                uart_axi_bresp  = (s_addr == 4'h4) ? 2'b00 : pass_resp;
                s_aw_seen = 0; s_w_seen = 0;
            end
            if (uart_axi_awvalid && !s_prev_av && mon_n < 64) begin
                mon_addr[mon_n] = uart_axi_awaddr;
                mon_data[mon_n] = uart_axi_wdata;
                mon_strb[mon_n] = uart_axi_wstrb;
                mon_cyc[mon_n]  = cyc_cnt;
                mon_n++;
            end
            s_prev_av = uart_axi_awvalid;
            uart_axi_awready = !hold_aw;
            uart_axi_wready  = 1'b1;
            if (uart_axi_awvalid && uart_axi_awready) begin
                s_aw_seen = 1;
                s_addr    = uart_axi_awaddr;
            end
            if (uart_axi_wvalid && uart_axi_wready) s_w_seen = 1;
            if (uart_axi_bvalid && uart_axi_bready && mb_n < 64) begin
                s_b_fire = 1;
                mb_cyc[mb_n] = cyc_cnt + 1;
                mb_n++;
            end
        end
    end

    int         hs_cyc;
    bit         hs_ok;
    bit         got_b;
    logic [1:0] resp_b;
    int         lat_b;
    bit         launch_ok;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mmu_write(input logic [3:0] a, input logic [31:0] d,
                             input int aw_dly, input int w_dly);
        bit aw_done = 0;
        bit w_done  = 0;
        int n = 0;
        mmu_axi_awaddr = a;
        mmu_axi_awprot = 3'b000;
        mmu_axi_wdata  = d;
        mmu_axi_wstrb  = 4'hF;
        while (!(aw_done && w_done) && n < 100) begin
            @(negedge clk);
            mmu_axi_awvalid = !aw_done && (n >= aw_dly);
            mmu_axi_wvalid  = !w_done && (n >= w_dly);
            if (mmu_axi_awvalid && mmu_axi_awready) aw_done = 1;
            if (mmu_axi_wvalid && mmu_axi_wready) w_done = 1;
            n++;
        end
        hs_cyc = cyc_cnt + 1;
        hs_ok  = aw_done && w_done;
        @(negedge clk);
        mmu_axi_awvalid = 1'b0;
        mmu_axi_wvalid  = 1'b0;
    endtask

    task automatic wait_b(input int budget);
        got_b  = 0;
        resp_b = 2'bxx;
        lat_b  = -1;
        for (int i = 0; i < budget; i++) begin
            if (mmu_axi_bvalid) begin
                got_b  = 1;
                resp_b = mmu_axi_bresp;
                lat_b  = cyc_cnt - hs_cyc;
                mmu_axi_bready = 1'b1;
                @(negedge clk);
                mmu_axi_bready = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_launch(input int n, input int budget);
        launch_ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (mon_n >= n) begin
                launch_ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    int base;

    initial begin : stimulus
        rstn = 1'b0;
        mmu_axi_awaddr = '0; mmu_axi_awvalid = 1'b0; mmu_axi_awprot = '0;
        mmu_axi_wdata  = '0; mmu_axi_wstrb   = '0;   mmu_axi_wvalid = 1'b0;
        mmu_axi_bready = 1'b0;
        tick(3);

        // Reset values
        check("rst mmu_awready", mmu_axi_awready, 1);
        check("rst mmu_wready", mmu_axi_wready, 1);
        check("rst mmu_bvalid", mmu_axi_bvalid, 0);
        check("rst mmu_bresp", mmu_axi_bresp, 0);
        check("rst uart_awvalid", uart_axi_awvalid, 0);
        check("rst uart_wvalid", uart_axi_wvalid, 0);
        check("rst uart_bready", uart_axi_bready, 0);
        check("rst uart_awaddr", uart_axi_awaddr, 0);
        check("rst uart_awprot", uart_axi_awprot, 0);
        check("rst uart_wdata", uart_axi_wdata, 0);
        check("rst uart_wstrb", uart_axi_wstrb, 0);
        rstn = 1'b1;
        tick(2);

        // Single TX byte
        mmu_write(4'h4, 32'h0000_0041, 0, 0);
        check("t1 handshake", hs_ok, 1);
        wait_b(20);
        check("t1 bvalid", got_b, 1);
        check("t1 bresp", resp_b, 2'b00);
        check("t1 b latency", lat_b, 1);
        wait_launch(1, 20);
        check("t1 launch", launch_ok, 1);
        check("t1 awaddr", mon_addr[0], 4'h4);
        check("t1 wdata", mon_data[0], 32'h41);
        check("t1 wstrb", mon_strb[0], 4'b0001);
        check("t1 launch delay<=2", (mon_cyc[0] - hs_cyc) <= 2, 1);
        tick(40);

        // Burst of five bytes, acks back-to-back, launches spaced by the gap
        base = mon_n;
        for (int i = 0; i < 5; i++) begin
            mmu_write(4'h4, 32'h30 + i, 0, 0);
            wait_b(20);
            check("t2 bresp", {got_b, resp_b}, 3'b100);
            check("t2 b latency", lat_b, 1);
        end
        wait_launch(base + 5, 400);
        check("t2 launches", launch_ok, 1);
        for (int i = 0; i < 5; i++) begin
            check("t2 order", mon_data[base + i], 32'h30 + i);
            if (i > 0) check("t2 spacing", (mon_cyc[base + i] - mon_cyc[base + i - 1]) >= BYTE_CYCLES, 1);
        end
        tick(40);

        // CTRL write behind three queued bytes, UART answers SLVERR
        pass_resp = 2'b10;
        base = mon_n;
        for (int i = 0; i < 3; i++) begin
            mmu_write(4'h4, 32'h50 + i, 0, 0);
            wait_b(20);
            check("t3 tx bresp", {got_b, resp_b}, 3'b100);
        end
        mmu_write(4'hC, 32'h0000_0003, 0, 0);
        wait_b(300);
        check("t3 ctrl bvalid", got_b, 1);
        check("t3 ctrl bresp", resp_b, 2'b10);
        wait_launch(base + 4, 50);
        check("t3 launches", launch_ok, 1);
        check("t3 byte2", mon_data[base + 2], 32'h52);
        check("t3 ctrl awaddr", mon_addr[base + 3], 4'hC);
        check("t3 ctrl wdata", mon_data[base + 3], 32'h3);
        check("t3 ctrl wstrb", mon_strb[base + 3], 4'hF);
        check("t3 ctrl after tx bresp", mon_cyc[base + 3] > mb_cyc[base + 2], 1);
        pass_resp = 2'b00;
        tick(40);

        // AW leads W by 3 cycles, then W leads AW
        base = mon_n;
        mmu_write(4'h4, 32'h61, 0, 3);
        wait_b(20);
        check("t5 aw-first bresp", {got_b, resp_b}, 3'b100);
        mmu_write(4'h4, 32'h62, 3, 0);
        wait_b(20);
        check("t5 w-first bresp", {got_b, resp_b}, 3'b100);
        wait_launch(base + 2, 100);
        check("t5 launches", launch_ok, 1);
        check("t5 byte a", mon_data[base], 32'h61);
        check("t5 byte b", mon_data[base + 1], 32'h62);
        tick(60);
        check("t5 single push", mon_n, base + 2);

        // UART stalled: first byte sits in the drain, four fill the FIFO,
        // so the sixth write is the first that cannot be queued.
        hold_aw = 1'b1;
        base = mon_n;
        for (int i = 0; i < 5; i++) begin
            mmu_write(4'h4, 32'h70 + i, 0, 0);
            wait_b(20);
            check("t4 queued ack", {got_b, resp_b}, 3'b100);
        end
        mmu_write(4'h4, 32'h75, 0, 0);
        wait_b(30);
`ifdef UART_TX_BUFFER_OVERFLOW_DROP_EN
        check("t4 overflow bresp", {got_b, resp_b}, 3'b110);
        check("t4 drop count", tx_drop_count, 16'd1);
`else
        check("t4 overflow stalls", got_b, 0);
`endif
        check("t4 one launch", mon_n, base + 1);
        check("t4 uart awvalid held", uart_axi_awvalid, 1);

        // Reset while the drain is stuck in D_SEND with bytes queued
        rstn = 1'b0;
        #1;
        check("t6 uart_awvalid", uart_axi_awvalid, 0);
        check("t6 uart_wvalid", uart_axi_wvalid, 0);
        check("t6 uart_bready", uart_axi_bready, 0);
        check("t6 mmu_bvalid", mmu_axi_bvalid, 0);
        check("t6 mmu_awready", mmu_axi_awready, 1);
        check("t6 mmu_wready", mmu_axi_wready, 1);
        tick(2);
        hold_aw = 1'b0;
        rstn = 1'b1;
        base = mon_n;
        tick(50);
        check("t6 no launch after reset", mon_n, base);
        check("t6 uart idle", uart_axi_awvalid, 0);
`ifdef UART_TX_BUFFER_OVERFLOW_DROP_EN
        check("t6 drop count cleared", tx_drop_count, 16'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
